// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions.
//   XLEN, ILEN_BYTES : datapath width and instruction size in bytes
//   INSTR_NOP        : canonical NOP (addi x0, x0, 0)
//   fetch_state_e    : fetch-stage control states
//   fetch_entry_t    : one fetched instruction with its address
package rv32_pkg;

  localparam int          XLEN       = 32;
  localparam int          ILEN_BYTES = 4;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// Instruction queue: synchronous FIFO of fetch_entry_t.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : write push_data (accepted when not full, or full with a pop)
//   pop        : drop the head (ignored when empty)
//   clear      : empty the queue; overrides push and pop
//   head       : current head entry (valid when !empty)
//   count      : number of stored entries
//   empty/full : occupancy flags
module ifu_queue
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       clear,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_en;
  logic          pop_en;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_en  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

  // Storage is data only; pointers decide what is meaningful.
  always_ff @(posedge clk) begin
    if (push_en && !clear) mem[wr_ptr] <= push_data;
  end

  // The fetch credit rule must never let a push hit a full queue without a pop.
  always_ff @(posedge clk) begin
    if (rst_n && !clear) begin
      assert (!(push && full && !pop_en));
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// RV32I instruction fetch stage.
//   clk, rst_n              : clock, synchronous active-low reset
//   imem_req_*              : word fetch request channel (valid/ready)
//   imem_rsp_*              : in-order responses, no backpressure
//   instr_*_ifu_2_dec_o     : queue head {instruction, address} to decoder
//   dec_ready_i             : decoder consumes the head
//   flush_from_exe/dec      : redirects (execute has priority) with targets
module ifu_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic [31:0] instr_ifu_2_dec_o,
  output logic [31:0] instr_addr_ifu_2_dec_o,
  output logic        instr_valid_ifu_2_dec_o,
  input  logic        dec_ready_i,
  input  logic        flush_from_exe,
  input  logic [31:0] flush_addr_exe,
  input  logic        flush_from_dec,
  input  logic [31:0] flush_addr_dec
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   kill_cnt;
  logic [CW-1:0]   kill_cnt_nxt;
  logic [CW-1:0]   in_flight_after;
  logic [CW-1:0]   q_count;
  logic            flush;
  logic [XLEN-1:0] flush_sel;
  logic [XLEN-1:0] flush_target;
  logic            req_fire;
  logic            rsp_accept;
  logic            q_push;
  logic            q_pop;
  logic            q_empty;
  logic            q_full;
  fetch_entry_t    q_head;
  fetch_entry_t    q_push_data;

  assign flush        = flush_from_exe || flush_from_dec;
  assign flush_sel    = flush_from_exe ? flush_addr_exe : flush_addr_dec;
  assign flush_target = {flush_sel[XLEN-1:2], 2'b00};

  // Responses with nothing in flight (e.g. stragglers from before a reset)
  // are ignored so the outstanding counter can never underflow.
  assign rsp_accept      = imem_rsp_valid_i && (outstanding != '0);
  assign in_flight_after = outstanding - CW'(rsp_accept);

  // ---- request stage: credit covers queue slots plus in-flight words ----
  assign imem_req_valid_o = (state == RUN)
                         && (({1'b0, outstanding} + {1'b0, q_count}) < (CW+1)'(FIFO_DEPTH))
                         && (outstanding < CW'(MAX_OUTSTANDING))
                         && !flush;
  assign imem_addr_o      = pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  always_comb begin
    kill_cnt_nxt = kill_cnt;
    if (flush) begin
      kill_cnt_nxt = in_flight_after;
    end else if (rsp_accept && (kill_cnt != '0)) begin
      kill_cnt_nxt = kill_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      kill_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_accept);
      kill_cnt    <= kill_cnt_nxt;

      if (flush) begin
        pc     <= flush_target;
        rsp_pc <= flush_target;
      end else begin
        if (req_fire) pc     <= pc + XLEN'(ILEN_BYTES);
        if (q_push)   rsp_pc <= rsp_pc + XLEN'(ILEN_BYTES);
      end

      case (state)
        IDLE:    state <= RUN;
        RUN:     if (flush && (in_flight_after != '0)) state <= DRAIN;
        DRAIN:   if (!flush && (kill_cnt_nxt == '0))   state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- response stage: in-order words tagged with rsp_pc into the queue ----
  assign q_push            = rsp_accept && (kill_cnt == '0) && !flush;
  assign q_pop             = !q_empty && dec_ready_i && !flush;
  assign q_push_data.addr  = rsp_pc;
  assign q_push_data.instr = imem_rsp_data_i;

  ifu_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .clear     (flush),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // ---- decoder stage: first-word fall-through from the queue head ----
  assign instr_valid_ifu_2_dec_o = !q_empty;
  assign instr_ifu_2_dec_o       = q_empty ? INSTR_NOP : q_head.instr;
  assign instr_addr_ifu_2_dec_o  = q_empty ? rsp_pc    : q_head.addr;

  logic unused_ok;
  assign unused_ok = q_full;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage of the RV32I core, directly upstream of the decoder.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small instruction queue and presents {instruction, address} pairs to the decoder with valid/ready.
- Redirects on flush from execute or decode and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction queue entries; power of two, 2..8.
- MAX_OUTSTANDING, 2, maximum accepted but unanswered imem requests; must be ≤ FIFO_DEPTH.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts the request.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_rsp_valid_i  in  1  response valid; responses arrive in request order; no backpressure.
- imem_rsp_data_i  in  32  fetched instruction word.
- instr_ifu_2_dec_o  out  32  instruction to the decoder.
- instr_addr_ifu_2_dec_o  out  32  address of instr_ifu_2_dec_o.
- instr_valid_ifu_2_dec_o  out  1  queue head valid.
- dec_ready_i  in  1  decoder consumes the head this cycle.
- flush_from_exe  in  1  execute redirect (branch or jump resolved).
- flush_addr_exe  in  32  execute redirect target.
- flush_from_dec  in  1  decode redirect.
- flush_addr_dec  in  32  decode redirect target.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc=RESET_PC, rsp_pc=RESET_PC.
  - Queue empty; outstanding=0; kill_cnt=0; state=IDLE.
  - imem_req_valid_o=0, imem_addr_o=RESET_PC, instr_valid_ifu_2_dec_o=0.
  - instr_ifu_2_dec_o=32'h0000_0013 (NOP), instr_addr_ifu_2_dec_o=RESET_PC.
  - Reset mid-operation drops all in-flight state. Responses arriving after reset, before a new request is accepted, are ignored; outstanding is never allowed to go negative.
- State machine:
  - IDLE→RUN unconditionally after one cycle.
  - RUN→DRAIN on a flush while (outstanding − response-this-cycle) > 0.
  - DRAIN→RUN when kill_cnt reaches 0.
  - A flush with nothing in flight stays in RUN.
- Issue (RUN only):
  - imem_req_valid_o = (outstanding + queue_count < FIFO_DEPTH) && (outstanding < MAX_OUTSTANDING) && no flush this cycle.
  - imem_addr_o = pc.
  - On the req_valid && req_ready handshake: pc += 4 with 32-bit wrap (32'hFFFF_FFFC → 0), outstanding += 1.
  - imem_addr_o stays stable while req_valid=1 and ready=0.
- Response handling:
  - Every rsp_valid decrements outstanding. Simultaneous issue and response leave it unchanged.
  - If kill_cnt > 0: discard the response, kill_cnt −= 1.
  - Otherwise: push {rsp_pc, data} into the queue, rsp_pc += 4.
  - The credit rule guarantees the queue never overflows; overflow is an assertion failure.
- Decoder interface:
  - Head is shown combinationally from the queue. instr_valid=!empty.
  - Pop on valid && dec_ready_i.
  - When empty, the instruction output is the NOP 32'h13.
  - Push and pop in the same cycle are both allowed, including when the queue is full.
- Flush:
  - flush_from_exe has priority over flush_from_dec.
  - Target bits [1:0] are forced to 0.
  - pc ← target, rsp_pc ← target.
  - Queue cleared; any pop or push that cycle is ignored.
  - kill_cnt ← outstanding − (rsp_valid this cycle ? 1 : 0). The response arriving that cycle is discarded.
  - No request is issued in the flush cycle.
  - A flush during DRAIN recomputes kill_cnt the same way and stays in DRAIN.
- Latency: response data is visible at the decoder the cycle after rsp_valid (first-word fall-through from the registered queue).

Decomposition:
- Shared package `rv32_pkg`:
  - XLEN=32, INSTR_NOP=32'h0000_0013, ILEN_BYTES=4.
  - Fetch state enum {IDLE, RUN, DRAIN}.
  - Struct fetch_entry_t {addr[31:0], instr[31:0]}.
- Sub-module: `ifu_queue`, a synchronous FIFO of fetch_entry_t with push, pop, clear, count, empty and full.

Test Plan:
- Reset release with mem always ready and 1-cycle response → requests at 0x0, 0x4, 0x8; decoder sees (0x0, data0) first; queue never exceeds 2 entries.
- Hold dec_ready_i=0 → at most FIFO_DEPTH accepted requests; req_valid drops to 0; no data lost when ready returns.
- flush_from_exe=1 to 0x100 with 2 responses outstanding → both responses discarded (state=DRAIN); next request at 0x100; first delivered address is 0x100.
- flush_from_exe (target 0x200) and flush_from_dec (target 0x300) in the same cycle → next fetch at 0x200.
- Flush target 0x0000_0103 → fetch at 0x0000_0100. pc=0xFFFF_FFFC → next fetch at 0x0000_0000.
- rst_n=0 mid-DRAIN with a late response → after reset, outputs are at reset values, first fetch at RESET_PC, the stray response is ignored and outstanding stays 0.
